// File: rtl/led_row_scanner_pkg.sv
// rtl/led_row_scanner_pkg.sv - shared constants, FSM encoding and helpers for the LED row scanner
package led_row_scanner_pkg;

  localparam int ROW_NUM         = 8;
  localparam int ROW_W           = 3;
  localparam int COL_NUM_DEFAULT = 8;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_DRIVE = 2'd2
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - double-buffered 8-row frame store with front/back select and write port
module led_frame_buffer
  import led_row_scanner_pkg::*;
#(
  parameter int COL_NUM = COL_NUM_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ROW_W-1:0]   wr_row,
  input  logic [COL_NUM-1:0] wr_data,
  input  logic               swap,
  input  logic [ROW_W-1:0]   rd_row,
  output logic [COL_NUM-1:0] front_data,
  output logic [COL_NUM-1:0] back_data
);

  logic [COL_NUM-1:0] bank_a [ROW_NUM];
  logic [COL_NUM-1:0] bank_b [ROW_NUM];
  logic               front_sel;

  // A write coincident with a swap uses the old select, so it lands in the bank becoming front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sel <= 1'b0;
      for (int i = 0; i < ROW_NUM; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        if (front_sel) begin
          bank_a[wr_row] <= wr_data;
        end else begin
          bank_b[wr_row] <= wr_data;
        end
      end
      if (swap) begin
        front_sel <= ~front_sel;
      end
    end
  end

  assign front_data = front_sel ? bank_b[rd_row] : bank_a[rd_row];
  assign back_data  = front_sel ? bank_a[rd_row] : bank_b[rd_row];

endmodule

// File: rtl/led_row_scanner.sv
// rtl/led_row_scanner.sv - blanked row scan FSM with frame-boundary buffer swap for the LED matrix
module led_row_scanner
  import led_row_scanner_pkg::*;
#(
  parameter int COL_NUM      = COL_NUM_DEFAULT,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               scan_en_i,
  input  logic               wr_en_i,
  input  logic [ROW_W-1:0]   wr_row_i,
  input  logic [COL_NUM-1:0] wr_data_i,
  input  logic               swap_req_i,
  output logic [ROW_W-1:0]   row_sel_o,
  output logic               decoder_en_o,
  output logic [COL_NUM-1:0] col_data_o,
  output logic               frame_start_o,
  output logic               swap_ack_o,
  output logic               swap_pending_o
);

  localparam int               CNT_W      = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROW_NUM - 1);

  scan_state_e        state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [ROW_W-1:0]   row_nxt;
  logic               enter_row;
  logic               frame_nxt;
  logic               swap_do;
  logic               service;
  logic [COL_NUM-1:0] front_data;
  logic [COL_NUM-1:0] back_data;
  logic [COL_NUM-1:0] entry_data;

  led_frame_buffer #(
    .COL_NUM (COL_NUM)
  ) u_frame_buffer (
    .clk        (clk_i),
    .rst        (rst_i),
    .wr_en      (wr_en_i),
    .wr_row     (wr_row_i),
    .wr_data    (wr_data_i),
    .swap       (swap_do),
    .rd_row     (row_nxt),
    .front_data (front_data),
    .back_data  (back_data)
  );

  // A request arriving on the boundary edge itself is serviced there, never carried over.
  assign service = swap_pending_o | swap_req_i;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    row_nxt   = row_sel_o;
    enter_row = 1'b0;
    frame_nxt = 1'b0;
    swap_do   = 1'b0;
    if (!scan_en_i) begin
      state_nxt = SCAN_IDLE;
      cnt_nxt   = '0;
      row_nxt   = '0;
    end else begin
      case (state_q)
        SCAN_IDLE: begin
          state_nxt = SCAN_BLANK;
          cnt_nxt   = BLANK_LOAD;
          row_nxt   = '0;
          enter_row = 1'b1;
          frame_nxt = 1'b1;
          swap_do   = service;
        end
        SCAN_BLANK: begin
          if (cnt_q == '0) begin
            state_nxt = SCAN_DRIVE;
            cnt_nxt   = DWELL_LOAD;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
        SCAN_DRIVE: begin
          if (cnt_q == '0) begin
            state_nxt = SCAN_BLANK;
            cnt_nxt   = BLANK_LOAD;
            enter_row = 1'b1;
            if (row_sel_o == LAST_ROW) begin
              row_nxt   = '0;
              frame_nxt = 1'b1;
              swap_do   = service;
            end else begin
              row_nxt = row_sel_o + ROW_W'(1);
            end
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
        default: begin
          state_nxt = SCAN_IDLE;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end
      endcase
    end
  end

  // On a swap the back bank becomes front this edge; forward a same-cycle write to it.
  always_comb begin
    entry_data = front_data;
    if (swap_do) begin
      entry_data = (wr_en_i && (wr_row_i == row_nxt)) ? wr_data_i : back_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= SCAN_IDLE;
      cnt_q          <= '0;
      row_sel_o      <= '0;
      decoder_en_o   <= 1'b0;
      col_data_o     <= '0;
      frame_start_o  <= 1'b0;
      swap_ack_o     <= 1'b0;
      swap_pending_o <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      row_sel_o     <= row_nxt;
      decoder_en_o  <= (state_nxt == SCAN_DRIVE);
      frame_start_o <= frame_nxt;
      swap_ack_o    <= swap_do;
      if (state_nxt == SCAN_IDLE) begin
        col_data_o <= '0;
      end else if (enter_row) begin
        col_data_o <= entry_data;
      end
      swap_pending_o <= swap_do ? 1'b0 : (swap_pending_o | swap_req_i);
    end
  end

endmodule

// File: tb/tb_led_row_scanner.sv
// tb/tb_led_row_scanner.sv - scoreboard bench for led_row_scanner against an arithmetic frame model
module tb_led_row_scanner;

  localparam int COL_NUM = 8;
  localparam int DWELL   = 4;
  localparam int BLANK   = 2;
  localparam int ROW_P   = DWELL + BLANK;
  localparam int FRAME   = 8 * ROW_P;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         scan_en  = 1'b0;
  logic         wr_en    = 1'b0;
  logic [2:0]   wr_row   = 3'd0;
  logic [7:0]   wr_data  = 8'd0;
  logic         swap_req = 1'b0;
  logic [2:0]   row_sel;
  logic         decoder_en;
  logic [7:0]   col_data;
  logic         frame_start;
  logic         swap_ack;
  logic         swap_pending;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  led_row_scanner #(
    .COL_NUM      (COL_NUM),
    .DWELL_CYCLES (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .scan_en_i      (scan_en),
    .wr_en_i        (wr_en),
    .wr_row_i       (wr_row),
    .wr_data_i      (wr_data),
    .swap_req_i     (swap_req),
    .row_sel_o      (row_sel),
    .decoder_en_o   (decoder_en),
    .col_data_o     (col_data),
    .frame_start_o  (frame_start),
    .swap_ack_o     (swap_ack),
    .swap_pending_o (swap_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic       en;
    logic [7:0] col;
    logic       fs;
    logic       ack;
    logic       pend;
  } exp_t;

  exp_t sb_q[$];

  // Reference: position in the frame is just cycles since scan start, modulo the frame period.
  logic [7:0] m_mem [2][8];
  int         m_front = 0;
  bit         m_pend  = 0;
  bit         m_scan  = 0;
  int         m_p     = 0;
  bit         m_bound;
  bit         m_swap;
  int         m_row;
  exp_t       m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++)
          m_mem[b][r] = 8'h00;
      m_front = 0;
      m_pend  = 0;
      m_scan  = 0;
      m_p     = 0;
      sb_q.delete();
    end else begin
      m_bound = 0;
      if (!scan_en) begin
        m_scan = 0;
      end else if (!m_scan) begin
        m_scan  = 1;
        m_p     = 0;
        m_bound = 1;
      end else begin
        m_p     = m_p + 1;
        m_bound = ((m_p % FRAME) == 0);
      end
      m_swap = m_bound && (m_pend || swap_req);
      if (wr_en) m_mem[1 - m_front][wr_row] = wr_data;
      if (m_swap) m_front = 1 - m_front;
      m_pend = m_swap ? 1'b0 : (m_pend | swap_req);
      if (m_scan) begin
        m_row   = (m_p % FRAME) / ROW_P;
        m_e.row = 3'(m_row);
        m_e.en  = ((m_p % ROW_P) >= BLANK);
        m_e.col = m_mem[m_front][m_row];
      end else begin
        m_e.row = 3'd0;
        m_e.en  = 1'b0;
        m_e.col = 8'h00;
      end
      m_e.fs   = m_bound;
      m_e.ack  = m_swap;
      m_e.pend = m_pend;
      sb_q.push_back(m_e);
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  exp_t       mon_e;
  logic [2:0] prev_row;
  logic [7:0] prev_col;
  bit         have_prev = 0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({row_sel, decoder_en, col_data, frame_start, swap_ack, swap_pending} != 15'd0) begin
        errors++;
        $display("FAIL reset_hold: row=%0d en=%b col=%h fs=%b ack=%b pend=%b, expected all 0",
                 row_sel, decoder_en, col_data, frame_start, swap_ack, swap_pending);
      end
      have_prev = 0;
    end else begin
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if (row_sel !== mon_e.row || decoder_en !== mon_e.en || col_data !== mon_e.col ||
            frame_start !== mon_e.fs || swap_ack !== mon_e.ack || swap_pending !== mon_e.pend) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got row=%0d en=%b col=%h fs=%b ack=%b pend=%b, expected row=%0d en=%b col=%h fs=%b ack=%b pend=%b",
                   $time, row_sel, decoder_en, col_data, frame_start, swap_ack, swap_pending,
                   mon_e.row, mon_e.en, mon_e.col, mon_e.fs, mon_e.ack, mon_e.pend);
        end
      end
      if (have_prev && (row_sel != prev_row || col_data != prev_col)) begin
        checks++;
        if (decoder_en) begin
          errors++;
          $display("FAIL ghost_guard t=%0t: row/col changed with en=%b, expected en=0", $time, decoder_en);
        end
      end
      prev_row  = row_sel;
      prev_col  = col_data;
      have_prev = 1;
      if (swap_ack) ack_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int  a0;
  int  nz;
  bit  found;
  logic pend_before;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (9) tick();

    // scan start and first-row timing
    scan_en = 1'b1;
    tick();
    chk("frame_start_first", frame_start, 1);
    chk("start_row0", row_sel, 0);
    chk("start_blank_en", decoder_en, 0);
    repeat (2) tick();
    chk("drive_en", decoder_en, 1);
    repeat (4) tick();
    chk("row1_sel", row_sel, 1);
    chk("row1_blank_en", decoder_en, 0);

    // load back buffer mid-frame, request swap
    found = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_scan && m_p >= FRAME && (m_p % FRAME) == 10) begin found = 1; break; end
      tick();
    end
    chk("wait_midframe", found, 1);
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_row  = 3'(i);
      wr_data = 8'(1 << i);
      tick();
    end
    wr_en    = 1'b0;
    swap_req = 1'b1;
    a0 = ack_cnt;
    tick();
    swap_req = 1'b0;
    chk("pending_set", swap_pending, 1);
    found = 0;
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      if (swap_ack) begin found = 1; break; end
    end
    chk("swap_ack_seen", found, 1);
    chk("pending_cleared", swap_pending, 0);
    chk("new_frame_row0", col_data, 8'h01);
    repeat (7 * ROW_P) tick();
    chk("new_frame_row7_sel", row_sel, 7);
    chk("new_frame_row7_col", col_data, 8'h80);
    repeat (FRAME) tick();
    chk("single_ack", ack_cnt - a0, 1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      swap_req = ($urandom_range(0, 29) == 0);
      if (scan_en) begin
        if ($urandom_range(0, 79) == 0) scan_en = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        scan_en = 1'b1;
      end
      tick();
    end
    wr_en    = 1'b0;
    swap_req = 1'b0;
    scan_en  = 1'b1;

    // drop enable during DRIVE of row 3
    found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (row_sel == 3'd3 && decoder_en) begin found = 1; break; end
    end
    chk("wait_row3_drive", found, 1);
    pend_before = swap_pending;
    scan_en = 1'b0;
    tick();
    chk("off_en", decoder_en, 0);
    chk("off_row", row_sel, 0);
    chk("off_col", col_data, 0);
    chk("off_pend_kept", swap_pending, pend_before);
    repeat (3) tick();
    scan_en = 1'b1;
    tick();
    chk("restart_fs", frame_start, 1);
    chk("restart_row", row_sel, 0);

    // swap request and write landing on the service edge
    found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (!swap_pending && m_scan && (m_p % FRAME) == FRAME - 1) begin found = 1; break; end
    end
    chk("wait_service_cycle", found, 1);
    swap_req = 1'b1;
    wr_en    = 1'b1;
    wr_row   = 3'd0;
    wr_data  = 8'hAA;
    a0 = ack_cnt;
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    chk("svc_ack", swap_ack, 1);
    chk("svc_pend", swap_pending, 0);
    chk("svc_row0_col", col_data, 8'hAA);
    tick();
    chk("svc_ack_pulse", swap_ack, 0);
    repeat (FRAME) tick();
    chk("svc_single_ack", ack_cnt - a0, 1);

    // asynchronous reset during BLANK
    found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (row_sel == 3'd2 && !decoder_en) begin found = 1; break; end
    end
    chk("wait_blank_row2", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_row", row_sel, 0);
    chk("async_col", col_data, 0);
    chk("async_pend", swap_pending, 0);
    chk("async_fs_ack", {frame_start, swap_ack}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    nz = 0;
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      if (col_data != 8'h00) nz++;
    end
    chk("cleared_buffers", nz, 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
